// File: rtl/function_chooser_arb_if.sv
// rtl/function_chooser_arb_if.sv - request/grant bundle between request sources, the arbiter and function units
interface function_chooser_arb_if #(
    parameter int N = 2
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  reqs;
    logic          done;
    logic [N-1:0]  sets;
    logic          fin;
    logic [IW-1:0] sel;
    logic [N-1:0]  pending;
    logic          overrun;

    modport master (
        output reqs, done,
        input  sets, fin, sel, pending, overrun
    );

    modport slave (
        input  reqs, done,
        output sets, fin, sel, pending, overrun
    );
endinterface

// File: rtl/function_chooser_arb.sv
// rtl/function_chooser_arb.sv - edge-captured request arbiter granting one function at a time (FC_ROUND_ROBIN_EN selects round-robin)
module function_chooser_arb #(
    parameter int  N  = 2,
    localparam int IW = $clog2(N)
) (
    input logic                   clk,
    input logic                   rst_n,
    function_chooser_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    state_t        state, state_d;
    logic [N-1:0]  reqs_q;
    logic [N-1:0]  rise;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  sets_q, sets_d;
    logic [IW-1:0] sel_q, sel_d;
    logic          overrun_q, overrun_d;
    logic          grant;
    logic [IW-1:0] win;
    logic [N-1:0]  win_mask;

    assign rise     = bus.reqs & ~reqs_q;
    assign win_mask = N'(1) << win;

`ifdef FC_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;
    logic [IW:0]   idx;
    logic          found;

    // Search starts at the pointer and wraps past N-1 back to 0.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N))
                idx = idx - (IW+1)'(N);
            if (!found && pending_q[idx[IW-1:0]]) begin
                win   = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (grant)
            ptr <= (win == IW'(N-1)) ? '0 : win + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int k = N-1; k >= 0; k--)
            if (pending_q[k])
                win = IW'(k);
    end
`endif

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (pending_q != '0) begin
                    grant   = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.done)
                    state_d = RELEASE;
            end
            RELEASE: begin
                if (pending_q != '0) begin
                    grant   = 1'b1;
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A grant is held only while staying in ACTIVE; every exit from ACTIVE zeroes it for one cycle.
    always_comb begin
        sets_d    = '0;
        sel_d     = '0;
        pending_d = (pending_q & ~(grant ? win_mask : '0)) | rise;
        overrun_d = overrun_q | (|(rise & pending_q));
        if (grant) begin
            sets_d = win_mask;
            sel_d  = win;
        end else if (state == ACTIVE && !bus.done) begin
            sets_d = sets_q;
            sel_d  = sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqs_q    <= '0;
            pending_q <= '0;
            sets_q    <= '0;
            sel_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            reqs_q    <= bus.reqs;
            pending_q <= pending_d;
            sets_q    <= sets_d;
            sel_q     <= sel_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sets    = sets_q;
    assign bus.fin     = |sets_q;
    assign bus.sel     = sel_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_function_chooser_arb.sv
// tb/tb_function_chooser_arb.sv - self-checking bench for function_chooser_arb with a cycle model and directed scenarios
module tb_function_chooser_arb;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    function_chooser_arb_if #(.N(N)) bus ();

    function_chooser_arb #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a channel is granted on any edge where no grant was held before it;
    // a held grant ends on the edge that samples done.
    int           m_grant = -1;
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_prev  = '0;
    logic         m_ovr   = 1'b0;
    int           m_ptr   = 0;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_clr;
    int           m_pick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grant = -1;
            m_pend  = '0;
            m_prev  = '0;
            m_ovr   = 1'b0;
            m_ptr   = 0;
        end else begin
            m_rise = bus.reqs & ~m_prev;
            m_prev = bus.reqs;
            m_clr  = '0;
            if (m_grant >= 0) begin
                if (bus.done)
                    m_grant = -1;
            end else if (m_pend != '0) begin
                m_pick = -1;
`ifdef FC_ROUND_ROBIN_EN
                for (int k = 0; k < N; k++)
                    if (m_pick < 0 && m_pend[(m_ptr + k) % N])
                        m_pick = (m_ptr + k) % N;
                m_ptr = (m_pick + 1) % N;
`else
                for (int k = 0; k < N; k++)
                    if (m_pick < 0 && m_pend[k])
                        m_pick = k;
`endif
                m_grant = m_pick;
                m_clr[m_pick] = 1'b1;
            end
            m_ovr  = m_ovr | (|(m_rise & m_pend));
            m_pend = (m_pend & ~m_clr) | m_rise;
        end
    end

    int   got[$];
    int   exp_q[$];
    logic prev_fin = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fin = 1'b0;
        end else begin
            check("sets",    32'(bus.sets),    (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
            check("fin",     32'(bus.fin),     (m_grant >= 0) ? 32'd1 : 32'd0);
            check("sel",     32'(bus.sel),     (m_grant >= 0) ? 32'(m_grant) : 32'd0);
            check("pending", 32'(bus.pending), 32'(m_pend));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
            if (bus.fin && !prev_fin)
                got.push_back(int'(bus.sel));
            prev_fin = bus.fin;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fin();
        int t = 0;
        while (!bus.fin && t < 20) begin
            cyc(1);
            t++;
        end
        check("grant_timeout", 32'(bus.fin), 32'd1);
    endtask

    task automatic serve(input int n);
        for (int j = 0; j < n; j++) begin
            wait_fin();
            bus.done = 1'b1;
            cyc(1);
            bus.done = 1'b0;
        end
    endtask

    task automatic check_order(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size())
                check(name, 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reqs = '0;
        bus.done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sets", 32'(bus.sets), 32'd0);
        check("rst_fin",  32'(bus.fin),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single pulse on ch1: pending after one edge, grant after two.
        bus.reqs = 4'b0010;
        cyc(1);
        bus.reqs = 4'b0000;
        check("s1_pending", 32'(bus.pending), 32'h2);
        check("s1_fin_early", 32'(bus.fin), 32'd0);
        cyc(1);
        check("s1_sets", 32'(bus.sets), 32'h2);
        check("s1_sel",  32'(bus.sel),  32'd1);
        check("s1_fin",  32'(bus.fin),  32'd1);
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        check("s1_release", 32'(bus.sets), 32'd0);
        cyc(3);

        // Simultaneous rises on ch0 and ch3.
        got.delete();
        bus.reqs = 4'b1001;
        cyc(1);
        bus.reqs = 4'b0000;
        serve(2);
`ifdef FC_ROUND_ROBIN_EN
        exp_q = '{3, 0};
`else
        exp_q = '{0, 3};
`endif
        check_order("s2_order");
        cyc(2);

        // Rises on ch2 then ch0 during a ch0 grant.
        got.delete();
        bus.reqs = 4'b0001;
        cyc(1);
        bus.reqs = 4'b0000;
        wait_fin();
        bus.reqs = 4'b0100;
        cyc(1);
        bus.reqs = 4'b0000;
        cyc(1);
        bus.reqs = 4'b0001;
        cyc(1);
        bus.reqs = 4'b0000;
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        check("s3_gap", 32'(bus.fin), 32'd0);
        serve(2);
`ifdef FC_ROUND_ROBIN_EN
        exp_q = '{0, 2, 0};
`else
        exp_q = '{0, 0, 2};
`endif
        check_order("s3_order");
        check("s3_overrun", 32'(bus.overrun), 32'd0);
        cyc(2);

        // Repeated ch1 edges while its request is still pending.
        got.delete();
        bus.reqs = 4'b0001;
        cyc(1);
        bus.reqs = 4'b0000;
        wait_fin();
        bus.reqs = 4'b0010;
        cyc(1);
        bus.reqs = 4'b0000;
        cyc(1);
        check("s4_ovr_first", 32'(bus.overrun), 32'd0);
        for (int r = 0; r < 2; r++) begin
            bus.reqs = 4'b0010;
            cyc(1);
            bus.reqs = 4'b0000;
            cyc(1);
        end
        check("s4_ovr_set", 32'(bus.overrun), 32'd1);
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        serve(1);
        cyc(6);
        exp_q = '{0, 1};
        check_order("s4_order");
        check("s4_ovr_sticky", 32'(bus.overrun), 32'd1);
        check("s4_idle", 32'(bus.fin), 32'd0);

        // Asynchronous reset mid-grant, ch2 held high across release.
        bus.reqs = 4'b1000;
        cyc(1);
        bus.reqs = 4'b0000;
        wait_fin();
        bus.reqs = 4'b0100;
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_sets",    32'(bus.sets),    32'd0);
        check("s5_fin",     32'(bus.fin),     32'd0);
        check("s5_pending", 32'(bus.pending), 32'd0);
        check("s5_sel",     32'(bus.sel),     32'd0);
        check("s5_overrun", 32'(bus.overrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        cyc(1);
        check("s5_pend_after", 32'(bus.pending), 32'h4);
        check("s5_fin_early",  32'(bus.fin),     32'd0);
        cyc(1);
        check("s5_sets_grant", 32'(bus.sets), 32'h4);
        check("s5_sel_grant",  32'(bus.sel),  32'd2);
        bus.reqs = 4'b0000;
        bus.done = 1'b1;
        cyc(1);
        bus.done = 1'b0;
        cyc(2);

        // done held in IDLE with no requests.
        bus.done = 1'b1;
        cyc(5);
        check("s6_fin", 32'(bus.fin), 32'd0);
        check("s6_pending", 32'(bus.pending), 32'd0);
        bus.done = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
